// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, slave FSM state encoding and the
// latched request record used by the SRAM slave.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [WB_DW-1:0]   dat;
    logic [WB_AW-1:0]   adr;
  } wb_req_t;

endpackage

// File: rtl/sram_bytewe.sv
// Synchronous single-port 32-bit RAM with per-byte write enables and a
// registered read port; drop-in point for a vendor SRAM macro.
module sram_bytewe #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; real RAM macros have
  // none, and a reset would force the whole array into flip-flops.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 classic slave in front of an on-chip SRAM with programmable
// wait states. Optional macro WB_SRAM_ADDR_ERR_EN: out-of-range addresses end with wb_err_o.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
);

  wb_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  wb_req_t    req_q, req_live, acc;
  logic       armed_q;
  logic       ack_q, err_q, rd_valid_q;
  logic       req_valid, accept, enter_resp, acc_err;
  logic       mem_en;
  logic [WB_DW-1:0] ram_q;

  assign req_valid = wb_cyc_i & wb_stb_i;
  assign req_live  = '{we: wb_we_i, sel: wb_sel_i, dat: wb_dat_i, adr: wb_adr_i};
  // armed_q is low on the edge that releases reset, so a request there is ignored.
  assign accept    = (state_q == IDLE) & armed_q & req_valid;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    acc        = req_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc = req_live;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!req_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 3'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_SRAM_ADDR_ERR_EN
  assign acc_err = |acc.adr[WB_AW-1:ADDR_W+2];
`else
  assign acc_err = 1'b0;
`endif

  // Byte offset (and, without the error check, the aliased upper bits) are don't-care.
  logic unused_adr;
  assign unused_adr = ^acc.adr;

  assign mem_en = enter_resp & ~acc_err;

  sram_bytewe #(.AW(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc.we),
    .sel   (acc.sel),
    .addr  (acc.adr[ADDR_W+1:2]),
    .wdata (acc.dat),
    .rdata (ram_q)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      req_q      <= '0;
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_resp & ~acc_err;
      err_q   <= enter_resp & acc_err;
      if (mem_en && !acc.we) rd_valid_q <= 1'b1;
      if (accept) req_q <= req_live;
    end
  end

  // The RAM read register is not reset; mask it until the first read after reset.
  assign wb_dat_o = rd_valid_q ? ram_q : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: three instances (0, 1 and 3 wait
// states), directed table, corner-case sequences and randomized traffic.
module tb_wb_sram_slave;

  localparam int NI = 3;
  localparam int WS [NI] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_i [NI];
  logic        stb_i [NI];
  logic        we_i  [NI];
  logic [31:0] adr_i [NI];
  logic [3:0]  sel_i [NI];
  logic [31:0] dat_i [NI];
  logic [31:0] dat_o [NI];
  logic        ack_o [NI];
  logic        err_o [NI];
  logic        rty_o [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_sram_slave #(.ADDR_W(12), .WAIT_CYCLES(WS[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_cyc_i (cyc_i[g]),
      .wb_stb_i (stb_i[g]),
      .wb_we_i  (we_i[g]),
      .wb_adr_i (adr_i[g]),
      .wb_sel_i (sel_i[g]),
      .wb_dat_i (dat_i[g]),
      .wb_dat_o (dat_o[g]),
      .wb_ack_o (ack_o[g]),
      .wb_err_o (err_o[g]),
      .wb_rty_o (rty_o[g])
    );
  end

  // Reference model: word contents per instance and the expected wb_dat_o.
  logic [31:0] mdl [int];
  logic [31:0] exp_do [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] adr);
`ifdef WB_SRAM_ADDR_ERR_EN
    return adr >= 32'h0000_4000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int key(input int d, input logic [31:0] adr);
    return d * 4096 + int'((adr / 4) % 4096);
  endfunction

  function automatic void model_apply(input int d, input bit we, input logic [31:0] adr,
                                      input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] w;
    int k;
    if (addr_err(adr)) return;
    k = key(d, adr);
    if (we) begin
      w = mdl.exists(k) ? mdl[k] : 32'h0;
      for (int i = 0; i < 4; i++) if (sel[i]) w[8*i +: 8] = dat[8*i +: 8];
      mdl[k] = w;
    end else begin
      exp_do[d] = mdl[k];
    end
  endfunction

  task automatic drive(input int d, input bit on, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    cyc_i[d] = on;
    stb_i[d] = on;
    we_i[d]  = we;
    adr_i[d] = adr;
    sel_i[d] = sel;
    dat_i[d] = dat;
  endtask

  // One complete transfer with latency, termination type, data and pulse-width checks.
  task automatic run_and_check(input int d, input bit we, input logic [31:0] adr,
                               input logic [3:0] sel, input logic [31:0] dat,
                               input bit exp_err, input logic [31:0] exp_dat);
    int lat = 0;
    bit got_ack = 0;
    bit got_err = 0;
    @(negedge clk);
    drive(d, 1'b1, we, adr, sel, dat);
    while (lat < 20 && !got_ack && !got_err) begin
      @(negedge clk);
      lat++;
      got_ack = ack_o[d];
      got_err = err_o[d];
    end
    check($sformatf("latency i%0d a%h", d, adr), lat, 1 + WS[d]);
    check($sformatf("term i%0d a%h", d, adr), {got_ack, got_err}, {~exp_err, exp_err});
    check($sformatf("dat_o i%0d a%h", d, adr), dat_o[d], exp_dat);
    drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check($sformatf("pulse1 i%0d a%h", d, adr), {ack_o[d], err_o[d]}, 2'b00);
  endtask

  typedef struct {
    int          d;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          exp_err;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vecs [$];

  initial begin
    for (int d = 0; d < NI; d++) begin
      drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      exp_do[d] = 32'h0;
    end

    vecs.push_back('{1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1, 1'b1, 32'h10, 4'h2, 32'h0000AA00, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1, 1'b0, 32'h10, 4'h1, 32'h0,        1'b0, 32'hDEADAAEF});
    vecs.push_back('{1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0, 32'hDEADAAEF});
    vecs.push_back('{1, 1'b0, 32'h13, 4'h0, 32'h0,        1'b0, 32'hDEADAAEF});
    vecs.push_back('{1, 1'b1, 32'h0,  4'hF, 32'hA5A55A5A, 1'b0, 32'hDEADAAEF});
`ifdef WB_SRAM_ADDR_ERR_EN
    vecs.push_back('{1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 1'b1, 32'hDEADAAEF});
`else
    vecs.push_back('{1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 1'b0, 32'hA5A55A5A});
`endif
    vecs.push_back('{0, 1'b1, 32'h0,  4'hF, 32'h11111111, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h4,  4'hF, 32'h22222222, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h8,  4'hF, 32'h33333333, 1'b0, 32'h0});
    vecs.push_back('{2, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{2, 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D});
    vecs.push_back('{2, 1'b1, 32'h20, 4'h9, 32'h11223344, 1'b0, 32'hCAFEF00D});
    vecs.push_back('{2, 1'b0, 32'h20, 4'h0, 32'h0,        1'b0, 32'h11FEF044});

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      check($sformatf("reset outs i%0d", d), {ack_o[d], err_o[d], rty_o[d]}, 3'b000);
      check($sformatf("reset dat i%0d", d), dat_o[d], 32'h0);
    end
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_and_check(vecs[i].d, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                    vecs[i].exp_err, vecs[i].exp_do);
      model_apply(vecs[i].d, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
    end

    // Back-to-back reads with strobe held, zero wait states
    begin
      int j = 0;
      bit prev = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check($sformatf("b2b ack c%0d", c), ack_o[0], (c % 2) == 0);
        check($sformatf("b2b adjacent c%0d", c), prev & ack_o[0], 1'b0);
        prev = ack_o[0];
        if (ack_o[0] && j < 3) begin
          check($sformatf("b2b dat w%0d", j), dat_o[0], mdl[key(0, j * 4)]);
          exp_do[0] = mdl[key(0, j * 4)];
          j++;
          adr_i[0] = 32'(j * 4);
        end
        if (c == 5) drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      check("b2b count", j, 3);
    end

    // Abort: strobe dropped in the second wait cycle of a 3-wait write
    begin
      int seen = 0;
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
      @(negedge clk);
      seen += int'(ack_o[2] | err_o[2]);
      @(negedge clk);
      seen += int'(ack_o[2] | err_o[2]);
      drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (8) begin
        @(negedge clk);
        seen += int'(ack_o[2] | err_o[2]);
      end
      check("abort no ack", seen, 0);
      check("abort dat_o", dat_o[2], exp_do[2]);
      run_and_check(2, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, mdl[key(2, 32'h20)]);
      model_apply(2, 1'b0, 32'h20, 4'hF, 32'h0);
    end

    // Reset asserted while a write is in its wait state
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'h55555555);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid ack", ack_o[1], 1'b0);
    for (int d = 0; d < NI; d++) check($sformatf("rst mid dat i%0d", d), dat_o[d], 32'h0);
    repeat (2) @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < NI; d++) exp_do[d] = 32'h0;
    run_and_check(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF);
    model_apply(1, 1'b0, 32'h10, 4'hF, 32'h0);

    // Randomized traffic: fill words 0..7 of each instance, then mixed accesses
    for (int d = 0; d < NI; d++) begin
      for (int w = 0; w < 8; w++) begin
        logic [31:0] v = $urandom;
        model_apply(d, 1'b1, 32'(w * 4), 4'hF, v);
        run_and_check(d, 1'b1, 32'(w * 4), 4'hF, v, 1'b0, exp_do[d]);
      end
    end
    for (int n = 0; n < 60; n++) begin
      int          d   = int'($urandom_range(0, NI - 1));
      bit          we  = 1'($urandom_range(0, 1));
      logic [31:0] adr = 32'($urandom_range(0, 7) * 4);
      logic [3:0]  sel = 4'($urandom);
      logic [31:0] dat = $urandom;
      bit          e;
      if ($urandom_range(0, 3) == 0) adr[31:14] = 18'($urandom_range(1, 18'h3FFFF));
      e = addr_err(adr);
      model_apply(d, we, adr, sel, dat);
      run_and_check(d, we, adr, sel, dat, e, exp_do[d]);
    end

    for (int d = 0; d < NI; d++) check($sformatf("rty i%0d", d), rty_o[d], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
